pwr_switch_sequencer: RTL and testbench

Power-state sequencer that drives the enable of a domain power switch cell and orders the surrounding isolation and retention controls. It sits directly upstream of the power switch. On power-down it isolates, saves, then opens the switch. On power-up it closes the switch, waits for the switch acknowledge, restores, then releases isolation. A missing acknowledge within a bounded window parks the block in a safe error state.

---
 rtl/pwr_switch_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pwr_switch_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwr_switch_sequencer
// Brief    : Orders power-switch enable, isolation and retention save/restore
//            for one switchable domain, with bounded switch-ack waits.
// Revision : 1.0 - initial release
// ============================================================================
module pwr_switch_sequencer #(
    parameter int ISO_SETTLE  = 4,
    parameter int SAVE_CYCLES = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pwr_up_req,
    input  logic pwr_down_req,
    input  logic switch_ack,
    input  logic clear_err,
    output logic power_enable,
    output logic iso_en,
    output logic save,
    output logic restore,
    output logic domain_on,
    output logic busy,
    output logic err
);

    localparam int c_MAX_AB = (ISO_SETTLE > SAVE_CYCLES) ? ISO_SETTLE : SAVE_CYCLES;
    localparam int c_MAX    = (c_MAX_AB > ACK_TIMEOUT) ? c_MAX_AB : ACK_TIMEOUT;
    localparam int c_CNT_W  = $clog2(c_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_ISO_LAST  = c_CNT_W'(ISO_SETTLE - 1);
    localparam logic [c_CNT_W-1:0] c_SAVE_LAST = c_CNT_W'(SAVE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ACK_LAST  = c_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT   = {c_CNT_W{1'b1}};

    localparam logic [3:0] c_ST_OFF     = 4'd0;
    localparam logic [3:0] c_ST_SW_ON   = 4'd1;
    localparam logic [3:0] c_ST_RESTORE = 4'd2;
    localparam logic [3:0] c_ST_DEISO   = 4'd3;
    localparam logic [3:0] c_ST_ON      = 4'd4;
    localparam logic [3:0] c_ST_ISO     = 4'd5;
    localparam logic [3:0] c_ST_SAVE    = 4'd6;
    localparam logic [3:0] c_ST_SW_OFF  = 4'd7;
    localparam logic [3:0] c_ST_ERR     = 4'd8;

    logic [3:0]         r_state;
    logic [3:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_first;

    logic w_power_enable;
    logic w_iso_en;
    logic w_save;
    logic w_restore;
    logic w_domain_on;
    logic w_busy;
    logic w_err;

    // Timed states exit on the edge where the counter shows D-1 cycles elapsed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_OFF: begin
                if (pwr_up_req) w_state_nxt = c_ST_SW_ON;
            end
            c_ST_SW_ON: begin
                if (switch_ack)                w_state_nxt = c_ST_RESTORE;
                else if (r_cnt == c_ACK_LAST)  w_state_nxt = c_ST_ERR;
            end
            c_ST_RESTORE: begin
                if (r_cnt == c_SAVE_LAST) w_state_nxt = c_ST_DEISO;
            end
            c_ST_DEISO: begin
                if (r_cnt == c_ISO_LAST) w_state_nxt = c_ST_ON;
            end
            c_ST_ON: begin
                if (pwr_down_req) w_state_nxt = c_ST_ISO;
            end
            c_ST_ISO: begin
                if (r_cnt == c_ISO_LAST) w_state_nxt = c_ST_SAVE;
            end
            c_ST_SAVE: begin
                if (r_cnt == c_SAVE_LAST) w_state_nxt = c_ST_SW_OFF;
            end
            c_ST_SW_OFF: begin
                if (!switch_ack)               w_state_nxt = c_ST_OFF;
                else if (r_cnt == c_ACK_LAST)  w_state_nxt = c_ST_ERR;
            end
            c_ST_ERR: begin
                if (clear_err) w_state_nxt = c_ST_OFF;
            end
            default: w_state_nxt = c_ST_OFF;
        endcase
    end

    assign w_first = (w_state_nxt != r_state);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_first)                w_cnt_nxt = '0;
        else if (r_cnt != c_CNT_SAT) w_cnt_nxt = r_cnt + 1'b1;
    end

    // Outputs are decoded from the upcoming state so they register on the same
    // edge the state changes.
    always_comb begin
        w_power_enable = 1'b0;
        w_iso_en       = 1'b1;
        w_save         = 1'b0;
        w_restore      = 1'b0;
        w_domain_on    = 1'b0;
        w_busy         = 1'b0;
        w_err          = 1'b0;
        case (w_state_nxt)
            c_ST_SW_ON: begin
                w_power_enable = 1'b1;
                w_busy         = 1'b1;
            end
            c_ST_RESTORE: begin
                w_power_enable = 1'b1;
                w_restore      = w_first;
                w_busy         = 1'b1;
            end
            c_ST_DEISO, c_ST_ISO: begin
                w_power_enable = 1'b1;
                w_busy         = 1'b1;
            end
            c_ST_ON: begin
                w_power_enable = 1'b1;
                w_iso_en       = 1'b0;
                w_domain_on    = 1'b1;
            end
            c_ST_SAVE: begin
                w_power_enable = 1'b1;
                w_save         = w_first;
                w_busy         = 1'b1;
            end
            c_ST_SW_OFF: begin
                w_busy = 1'b1;
            end
            c_ST_ERR: begin
                w_err = 1'b1;
            end
            default: begin
                w_power_enable = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_OFF;
            r_cnt        <= '0;
            power_enable <= 1'b0;
            iso_en       <= 1'b1;
            save         <= 1'b0;
            restore      <= 1'b0;
            domain_on    <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            power_enable <= w_power_enable;
            iso_en       <= w_iso_en;
            save         <= w_save;
            restore      <= w_restore;
            domain_on    <= w_domain_on;
            busy         <= w_busy;
            err          <= w_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwr_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwr_switch_sequencer
// Brief    : Directed self-checking bench for pwr_switch_sequencer (defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwr_switch_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic pwr_up_req;
    logic pwr_down_req;
    logic switch_ack;
    logic clear_err;
    logic power_enable;
    logic iso_en;
    logic save;
    logic restore;
    logic domain_on;
    logic busy;
    logic err;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation order: {power_enable, iso_en, save, restore, domain_on, busy, err}
    localparam logic [6:0] c_OFF     = 7'b0100000;
    localparam logic [6:0] c_TRANS   = 7'b1100010;
    localparam logic [6:0] c_RESTORE = 7'b1101010;
    localparam logic [6:0] c_ON      = 7'b1000100;
    localparam logic [6:0] c_ERR     = 7'b0100001;

    always #5 clk = ~clk;

    pwr_switch_sequencer #(
        .ISO_SETTLE  (4),
        .SAVE_CYCLES (2),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pwr_up_req   (pwr_up_req),
        .pwr_down_req (pwr_down_req),
        .switch_ack   (switch_ack),
        .clear_err    (clear_err),
        .power_enable (power_enable),
        .iso_en       (iso_en),
        .save         (save),
        .restore      (restore),
        .domain_on    (domain_on),
        .busy         (busy),
        .err          (err)
    );

    function automatic logic [6:0] obs();
        return {power_enable, iso_en, save, restore, domain_on, busy, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pwr_up_req = 1'b0; pwr_down_req = 1'b0;
        switch_ack = 1'b0; clear_err = 1'b0;
        #1;
        n_checks++;
        if (obs() !== c_OFF) begin
            n_fail++; $display("FAIL reset_async: got %b expected %b", obs(), c_OFF);
        end
        repeat (2) tick();
        #2 rst = 1'b0;
        tick();
        n_checks++;
        if (obs() !== c_OFF) begin
            n_fail++; $display("FAIL reset_release: got %b expected %b", obs(), c_OFF);
        end
        pwr_down_req = 1'b1;
        repeat (2) tick();
        pwr_down_req = 1'b0;
        n_checks++;
        if (obs() !== c_OFF) begin
            n_fail++; $display("FAIL down_in_off: got %b expected %b", obs(), c_OFF);
        end
    endtask

    task automatic test_power_up();
        logic [6:0] exp;
        switch_ack = 1'b0;
        pwr_up_req = 1'b1;
        tick();
        n_checks++;
        if (obs() !== c_TRANS) begin
            n_fail++; $display("FAIL pwr_up E0: got %b expected %b", obs(), c_TRANS);
        end
        for (int e = 1; e <= 9; e++) begin
            if (e == 3) switch_ack = 1'b1;
            tick();
            exp = (e == 3) ? c_RESTORE : (e >= 9) ? c_ON : c_TRANS;
            n_checks++;
            if (obs() !== exp) begin
                n_fail++; $display("FAIL pwr_up E%0d: got %b expected %b", e, obs(), exp);
            end
        end
        pwr_up_req = 1'b0;
        tick();
        n_checks++;
        if (obs() !== c_ON) begin
            n_fail++; $display("FAIL pwr_up hold_on: got %b expected %b", obs(), c_ON);
        end
    endtask

    task automatic run_down_tail(input string name);
        logic [6:0] exp;
        for (int e = 1; e <= 7; e++) begin
            if (e == 7) switch_ack = 1'b0;
            tick();
            exp = {e < 6, 1'b1, e == 4, 1'b0, 1'b0, e < 7, 1'b0};
            n_checks++;
            if (obs() !== exp) begin
                n_fail++; $display("FAIL %s E%0d: got %b expected %b", name, e, obs(), exp);
            end
        end
    endtask

    task automatic test_power_down();
        pwr_down_req = 1'b1;
        tick();
        pwr_down_req = 1'b0;
        n_checks++;
        if (obs() !== c_TRANS) begin
            n_fail++; $display("FAIL pwr_down E0: got %b expected %b", obs(), c_TRANS);
        end
        run_down_tail("pwr_down");
    endtask

    task automatic test_up_timeout();
        switch_ack = 1'b0;
        pwr_up_req = 1'b1;
        tick();
        pwr_up_req = 1'b0;
        repeat (15) tick();
        n_checks++;
        if (obs() !== c_TRANS) begin
            n_fail++; $display("FAIL timeout E15: got %b expected %b", obs(), c_TRANS);
        end
        tick();
        n_checks++;
        if (obs() !== c_ERR) begin
            n_fail++; $display("FAIL timeout E16: got %b expected %b", obs(), c_ERR);
        end
        pwr_up_req = 1'b1;
        tick();
        pwr_up_req = 1'b0;
        n_checks++;
        if (obs() !== c_ERR) begin
            n_fail++; $display("FAIL timeout err_hold: got %b expected %b", obs(), c_ERR);
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_checks++;
        if (obs() !== c_OFF) begin
            n_fail++; $display("FAIL timeout clear: got %b expected %b", obs(), c_OFF);
        end
    endtask

    task automatic test_ack_on_timeout_edge();
        switch_ack = 1'b0;
        pwr_up_req = 1'b1;
        tick();
        pwr_up_req = 1'b0;
        repeat (15) tick();
        switch_ack = 1'b1;
        tick();
        n_checks++;
        if (obs() !== c_RESTORE) begin
            n_fail++; $display("FAIL ack_edge E16: got %b expected %b", obs(), c_RESTORE);
        end
        repeat (5) tick();
        n_checks++;
        if (obs() !== c_TRANS) begin
            n_fail++; $display("FAIL ack_edge E21: got %b expected %b", obs(), c_TRANS);
        end
        tick();
        n_checks++;
        if (obs() !== c_ON) begin
            n_fail++; $display("FAIL ack_edge E22: got %b expected %b", obs(), c_ON);
        end
    endtask

    task automatic test_both_requests();
        pwr_up_req   = 1'b1;
        pwr_down_req = 1'b1;
        tick();
        pwr_down_req = 1'b0;
        n_checks++;
        if (obs() !== c_TRANS) begin
            n_fail++; $display("FAIL both_req E0: got %b expected %b", obs(), c_TRANS);
        end
        run_down_tail("both_req");
        tick();
        n_checks++;
        if (obs() !== c_TRANS) begin
            n_fail++; $display("FAIL both_req rearm: got %b expected %b", obs(), c_TRANS);
        end
    endtask

    task automatic test_reset_mid_restore();
        logic [6:0] exp;
        switch_ack = 1'b1;
        tick();
        pwr_up_req = 1'b0;
        n_checks++;
        if (obs() !== c_RESTORE) begin
            n_fail++; $display("FAIL rst_mid restore: got %b expected %b", obs(), c_RESTORE);
        end
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs() !== c_OFF) begin
            n_fail++; $display("FAIL rst_mid async: got %b expected %b", obs(), c_OFF);
        end
        switch_ack = 1'b0;
        tick();
        #2 rst = 1'b0;
        tick();
        n_checks++;
        if (obs() !== c_OFF) begin
            n_fail++; $display("FAIL rst_mid off: got %b expected %b", obs(), c_OFF);
        end
        pwr_up_req = 1'b1;
        tick();
        pwr_up_req = 1'b0;
        switch_ack = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            exp = (e == 1) ? c_RESTORE : (e == 7) ? c_ON : c_TRANS;
            n_checks++;
            if (obs() !== exp) begin
                n_fail++; $display("FAIL rst_mid reup E%0d: got %b expected %b", e, obs(), exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        test_up_timeout();
        test_ack_on_timeout_edge();
        test_both_requests();
        test_reset_mid_restore();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
